microgreen_feature_averager: RTL and testbench

//   Upstream conditioning stage for the binary microgreen classifier. Accepts raw 4-bit

---
 rtl/microgreen_feature_averager.sv | 141 ++++++++++++++
 tb/tb_microgreen_feature_averager.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/microgreen_feature_averager.sv
// microgreen_feature_averager
//   Conditioning stage in front of the binary microgreen classifier. Raw 4-bit
//   samples of four features arrive over a valid/ready handshake. The stage sums
//   2**LOG2_N of them and presents one floor-averaged frame, plus its thresholded
//   (binarized) form, over a second valid/ready handshake.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   ena           in   clock enable; 0 freezes every register and blocks both handshakes
//   clr           in   synchronous flush of the partial sums and of any pending frame
//   sample_valid  in   raw sample present
//   sample_data   in   {stem[15:12], width[11:8], color[7:4], height[3:0]}, unsigned
//   sample_ready  out  stage can accept a sample (combinational)
//   feat_valid    out  averaged frame available
//   feat_ready    in   downstream accepts the frame
//   feat_data     out  averaged frame, same field packing as sample_data
//   feat_bin      out  {stem,width,color,height} >= THRESH
//   sample_cnt    out  samples summed into the current frame (0..N-1)
module microgreen_feature_averager #(
  parameter int LOG2_N = 2,
  parameter int THRESH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        clr,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready,
  output logic        feat_valid,
  input  logic        feat_ready,
  output logic [15:0] feat_data,
  output logic [3:0]  feat_bin,
  output logic [4:0]  sample_cnt
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = 4 + LOG2_N;  // 15*N < 16*N, so a sum of N samples never wraps

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [3:0][ACC_W-1:0]   acc_q, acc_d;
  logic [3:0][ACC_W-1:0]   sum_w;
  logic [4:0]              cnt_q, cnt_d;
  logic                    feat_valid_q, feat_valid_d;
  logic [15:0]             feat_data_q, feat_data_d;
  logic [3:0]              feat_bin_q, feat_bin_d;
  logic                    accept;

  // Floor average: the sum of N samples shifted down; the result always fits 4 bits.
  function automatic logic [3:0] avg_field(input logic [ACC_W-1:0] s);
    return 4'(s >> LOG2_N);
  endfunction

  function automatic logic bin_field(input logic [3:0] f);
    return f >= 4'(THRESH);
  endfunction

  assign sample_ready = ena & rst_n & (state_q == ACCUM) & ~clr;
  assign accept       = sample_valid & sample_ready;

  assign feat_valid = feat_valid_q;
  assign feat_data  = feat_data_q;
  assign feat_bin   = feat_bin_q;
  assign sample_cnt = cnt_q;

  // Running sum including the sample on the bus; only committed on accept.
  always_comb begin
    sum_w = '0;
    for (int i = 0; i < 4; i++) begin
      sum_w[i] = acc_q[i] + ACC_W'(sample_data[4*i +: 4]);
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    feat_valid_d = feat_valid_q;
    feat_data_d  = feat_data_q;
    feat_bin_d   = feat_bin_q;

    if (ena) begin
      if (clr) begin
        // Flush wins over everything, including a frame being handed off this cycle.
        acc_d        = '0;
        cnt_d        = '0;
        feat_valid_d = 1'b0;
        state_d      = ACCUM;
      end else begin
        unique case (state_q)
          ACCUM: begin
            if (accept) begin
              if (cnt_q == 5'(N - 1)) begin
                for (int i = 0; i < 4; i++) begin
                  feat_data_d[4*i +: 4] = avg_field(sum_w[i]);
                  feat_bin_d[i]         = bin_field(avg_field(sum_w[i]));
                end
                feat_valid_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
                state_d      = HOLD;
              end else begin
                acc_d = sum_w;
                cnt_d = cnt_q + 5'd1;
              end
            end
          end
          HOLD: begin
            if (feat_valid_q && feat_ready) begin
              feat_valid_d = 1'b0;
              state_d      = ACCUM;
            end
          end
          default: state_d = ACCUM;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      feat_valid_q <= 1'b0;
      feat_data_q  <= '0;
      feat_bin_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      feat_valid_q <= feat_valid_d;
      feat_data_q  <= feat_data_d;
      feat_bin_q   <= feat_bin_d;
    end
  end

endmodule

// File: tb/tb_microgreen_feature_averager.sv
module tb_microgreen_feature_averager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        clr = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_ready;
  logic        feat_valid;
  logic        feat_ready = 1'b0;
  logic [15:0] feat_data;
  logic [3:0]  feat_bin;
  logic [4:0]  sample_cnt;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];  // {feat_data, feat_bin}

  microgreen_feature_averager #(.LOG2_N(2), .THRESH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
    .feat_bin(feat_bin), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: a frame handshake is seen half a cycle before the edge that completes it.
  always @(negedge clk) begin
    if (rst_n && ena && !clr && feat_valid && feat_ready) begin
      logic [19:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got %h/%b expected none", feat_data, feat_bin);
      end else begin
        e = exp_q.pop_front();
        if ({feat_data, feat_bin} !== e) begin
          errors++;
          $display("FAIL frame: got %h/%b expected %h/%b", feat_data, feat_bin, e[19:4], e[3:0]);
        end
      end
    end
  end

  // Present one sample and hold it until accepted (bounded wait).
  task automatic send(input logic [15:0] d);
    bit ok = 0;
    sample_valid = 1'b1;
    sample_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (sample_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got sample_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    // Test 1: reset
    #2;
    @(negedge clk);
    check("rst_feat_valid", feat_valid, 0);
    check("rst_feat_data", feat_data, 0);
    check("rst_feat_bin", feat_bin, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    check("rst_sample_ready", sample_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_sample_ready", sample_ready, 1);

    // Test 2: average of heights 1,2,3,5 with other fields 0xF
    @(posedge clk); #1;
    exp_q.push_back({16'hFFF2, 4'b1110});
    send(16'hFFF1);
    send(16'hFFF2);
    check("cnt_after_2", sample_cnt, 2);
    send(16'hFFF3);
    send(16'hFFF5);
    check("avg_valid_after_4th", feat_valid, 1);
    check("avg_data", feat_data, 16'hFFF2);

    // Test 3: backpressure with an extra sample offered
    sample_valid = 1'b1;
    sample_data  = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data_stable", feat_data, 16'hFFF2);
      check("bp_valid_held", feat_valid, 1);
      check("bp_ready_low", sample_ready, 0);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    check("bp_cnt_untouched", sample_cnt, 0);
    feat_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_dropped", feat_valid, 0);
    check("bp_data_kept", feat_data, 16'hFFF2);
    @(negedge clk);
    check("bp_ready_back", sample_ready, 1);
    @(posedge clk); #1;

    // Test 4: threshold edge
    exp_q.push_back({16'h7777, 4'b0000});
    for (int i = 0; i < 4; i++) send(16'h7777);
    exp_q.push_back({16'h8888, 4'b1111});
    for (int i = 0; i < 4; i++) send(16'h8888);

    // Test 5: clr after 2 samples, then clean frame
    send(16'h1111);
    send(16'hEEEE);
    check("pre_clr_cnt", sample_cnt, 2);
    clr = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 16'hEEEE;
    @(negedge clk);
    check("clr_ready_low", sample_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    sample_valid = 1'b0;
    check("clr_cnt_zero", sample_cnt, 0);
    exp_q.push_back({16'h9999, 4'b1111});
    for (int i = 0; i < 4; i++) send(16'h9999);

    // Test 6a: ena=0 mid-frame freezes the counter and ignores samples
    send(16'h3333);
    send(16'h3333);
    check("pre_ena_cnt", sample_cnt, 2);
    ena = 1'b0;
    sample_valid = 1'b1;
    sample_data  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ena0_ready_low", sample_ready, 0);
      @(posedge clk); #1;
      check("ena0_cnt_frozen", sample_cnt, 2);
    end
    sample_valid = 1'b0;
    ena = 1'b1;
    exp_q.push_back({16'h4444, 4'b0000});
    send(16'h5555);
    send(16'h5555);

    // Test 6b: async reset while a frame is held
    @(posedge clk); #1;
    feat_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'hAAAA);
    check("hold_valid", feat_valid, 1);
    check("hold_data", feat_data, 16'hAAAA);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", feat_valid, 0);
    check("arst_data", feat_data, 0);
    check("arst_bin", feat_bin, 0);
    check("arst_ready", sample_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_rel_ready", sample_ready, 1);
    check("arst_rel_valid", feat_valid, 0);

    repeat (3) @(posedge clk);
    check("frames_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
